// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface if_fetch_unit_if;
  logic        MemReq_o;
  logic [31:0] MemAddr_o;
  logic        MemAck_i;
  logic [31:0] MemData_i;

  modport master (
    output MemReq_o,
    output MemAddr_o,
    input  MemAck_i,
    input  MemData_i
  );

  modport slave (
    input  MemReq_o,
    input  MemAddr_o,
    output MemAck_i,
    output MemData_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding request, stall via HOLD,
// redirect during an outstanding request via DROP (response discarded).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   HD_i,
  input  logic                   Branch_i,
  input  logic [31:0]            BranchAddr_i,
  if_fetch_unit_if.master        mem,
  output logic [31:0]            PC_o,
  output logic [31:0]            ReadData_o,
  output logic                   Valid_o
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  logic [31:0] req_plus4;
  logic        req_c;
  logic        valid_c;
  logic [31:0] rdata_c;
  logic [31:0] pc_out_c;

  assign req_plus4 = req_addr_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    hold_data_d = hold_data_q;
    hold_pc_d   = hold_pc_q;
    req_c       = 1'b0;
    valid_c     = 1'b0;
    rdata_c     = 32'h0;
    pc_out_c    = 32'h0;

    case (state_q)
      ST_FETCH: begin
        req_c = 1'b1;
        if (Branch_i) begin
          pc_d = BranchAddr_i;
          if (mem.MemAck_i) begin
            req_addr_d = BranchAddr_i;
          end else begin
            // Request must stay on the bus until acked; its data is then junk.
            state_d = ST_DROP;
          end
        end else if (mem.MemAck_i) begin
          valid_c  = 1'b1;
          rdata_c  = mem.MemData_i;
          pc_out_c = req_plus4;
          if (HD_i) begin
            hold_data_d = mem.MemData_i;
            hold_pc_d   = req_plus4;
            state_d     = ST_HOLD;
          end else begin
            pc_d       = req_plus4;
            req_addr_d = req_plus4;
          end
        end
      end

      ST_HOLD: begin
        if (Branch_i) begin
          pc_d       = BranchAddr_i;
          req_addr_d = BranchAddr_i;
          state_d    = ST_FETCH;
        end else begin
          valid_c  = 1'b1;
          rdata_c  = hold_data_q;
          pc_out_c = hold_pc_q;
          if (!HD_i) begin
            pc_d       = hold_pc_q;
            req_addr_d = hold_pc_q;
            state_d    = ST_FETCH;
          end
        end
      end

      ST_DROP: begin
        req_c = 1'b1;
        if (Branch_i) begin
          pc_d = BranchAddr_i;
        end
        if (mem.MemAck_i) begin
          req_addr_d = Branch_i ? BranchAddr_i : pc_q;
          state_d    = ST_FETCH;
        end
      end

      default: begin
        state_d    = ST_FETCH;
        pc_d       = RESET_PC;
        req_addr_d = RESET_PC;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      hold_data_q <= 32'h0;
      hold_pc_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      hold_data_q <= hold_data_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

  // Outputs are forced quiet while reset is held so an in-flight request is abandoned at once.
  assign mem.MemReq_o  = req_c & ~rst_i;
  assign mem.MemAddr_o = rst_i ? RESET_PC : req_addr_q;
  assign Valid_o       = valid_c & ~rst_i;
  assign ReadData_o    = rst_i ? 32'h0 : rdata_c;
  assign PC_o          = rst_i ? 32'h0 : pc_out_c;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit; each row is one clock cycle.
module tb_if_fetch_unit;

  logic        clk_i;
  logic        rst_i;
  logic        HD_i;
  logic        Branch_i;
  logic [31:0] BranchAddr_i;
  logic [31:0] PC_o;
  logic [31:0] ReadData_o;
  logic        Valid_o;

  if_fetch_unit_if mem_bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .HD_i         (HD_i),
    .Branch_i     (Branch_i),
    .BranchAddr_i (BranchAddr_i),
    .mem          (mem_bus.master),
    .PC_o         (PC_o),
    .ReadData_o   (ReadData_o),
    .Valid_o      (Valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        hd;
    logic        br;
    logic [31:0] baddr;
    logic        ack;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_rdata;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic rst, logic hd, logic br, logic [31:0] baddr,
                              logic ack, logic [31:0] data, logic e_req,
                              logic [31:0] e_addr, logic e_valid,
                              logic [31:0] e_rdata, logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.hd = hd; v.br = br; v.baddr = baddr; v.ack = ack; v.data = data;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_rdata = e_rdata; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check32(string name, int row, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; HD_i = 1'b0; Branch_i = 1'b0; BranchAddr_i = 32'h0;
    mem_bus.MemAck_i = 1'b0; mem_bus.MemData_i = 32'h0;

    //            rst hd br baddr         ack data          req addr          v  rdata         pc
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0));
    // ack after 3 cycles for addr 0
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'hAAAA_0000, 1, 32'h0,       0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h2002_0005, 1, 32'h0,       1, 32'h2002_0005, 32'h4));
    // zero-wait back-to-back
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0000_0413, 1, 32'h4,       1, 32'h0000_0413, 32'h8));
    // ack for addr 8 with stall for 2 cycles
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h0000_0813, 1, 32'h8,       1, 32'h0000_0813, 32'hC));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h5555_5555, 0, 32'h8,       1, 32'h0000_0813, 32'hC));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h8,        1, 32'h0000_0813, 32'hC));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0000_0C13, 1, 32'hC,       1, 32'h0000_0C13, 32'h10));
    // branch to 0x40 while addr 16 outstanding, ack 2 cycles later
    vecs.push_back(mk(0, 0, 1, 32'h40,       0, 32'h0,        1, 32'h10,       0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'hDEAD_BEEF, 1, 32'h10,      0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hBAD0_BAD0, 1, 32'h10,      0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0000_4013, 1, 32'h40,      1, 32'h0000_4013, 32'h44));
    // branch and stall together while holding
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h0000_4413, 1, 32'h44,      1, 32'h0000_4413, 32'h48));
    vecs.push_back(mk(0, 1, 1, 32'h80,       0, 32'h0,        0, 32'h44,       0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0000_8013, 1, 32'h80,      1, 32'h0000_8013, 32'h84));
    // branch with ack in the same cycle: response discarded, stay fetching
    vecs.push_back(mk(0, 1, 1, 32'h100,      1, 32'hBAD1_BAD1, 1, 32'h84,      0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0001_0013, 1, 32'h100,     1, 32'h0001_0013, 32'h104));
    // two redirects during DROP: the latest wins
    vecs.push_back(mk(0, 0, 1, 32'h200,      0, 32'h0,        1, 32'h104,      0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h14,       0, 32'h0,        1, 32'h104,      0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hBAD2_BAD2, 1, 32'h104,     0, 32'h0,        32'h0));
    // request to 20 outstanding, then reset abandons it
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h14,       0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h1234_5678, 0, 32'h0,       0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0));
    // PC wrap from FFFF_FFFC
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hBAD3_BAD3, 1, 32'h0,      0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hFFFF_0013, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_0013, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0000_0013, 1, 32'h0,       1, 32'h0000_0013, 32'h4));

    @(posedge clk_i); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_i            = vecs[i].rst;
      HD_i             = vecs[i].hd;
      Branch_i         = vecs[i].br;
      BranchAddr_i     = vecs[i].baddr;
      mem_bus.MemAck_i = vecs[i].ack;
      mem_bus.MemData_i = vecs[i].data;
      @(negedge clk_i);
      $display("row %0d: rst=%0b hd=%0b br=%0b ack=%0b -> req=%0b addr=%h valid=%0b data=%h pc=%h",
               i, rst_i, HD_i, Branch_i, mem_bus.MemAck_i, mem_bus.MemReq_o,
               mem_bus.MemAddr_o, Valid_o, ReadData_o, PC_o);
      check32("mem_req",  i, {31'h0, mem_bus.MemReq_o}, {31'h0, vecs[i].e_req});
      check32("mem_addr", i, mem_bus.MemAddr_o,        vecs[i].e_addr);
      check32("valid",    i, {31'h0, Valid_o},          {31'h0, vecs[i].e_valid});
      check32("rdata",    i, ReadData_o,                vecs[i].e_rdata);
      check32("pc_out",   i, PC_o,                      vecs[i].e_pc);
      @(posedge clk_i); #1;
    end

    // Reset pulse entirely between clock edges must take effect on its own.
    HD_i = 1'b0; Branch_i = 1'b0; mem_bus.MemAck_i = 1'b0; mem_bus.MemData_i = 32'h0;
    #1 rst_i = 1'b1;
    #1;
    $display("async reset pulse: req=%0b addr=%h", mem_bus.MemReq_o, mem_bus.MemAddr_o);
    check32("async_rst_req", -1, {31'h0, mem_bus.MemReq_o}, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    $display("after async reset: req=%0b addr=%h valid=%0b", mem_bus.MemReq_o, mem_bus.MemAddr_o, Valid_o);
    check32("async_rst_addr",  -1, mem_bus.MemAddr_o, 32'h0);
    check32("async_rst_req2",  -1, {31'h0, mem_bus.MemReq_o}, 32'h1);
    check32("async_rst_valid", -1, {31'h0, Valid_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 HD_i  input  1  hazard stall from hazard detection; hold current instruction, no PC advance.
REQ-005 Branch_i  input  1  taken branch/jump redirect from ID; also flushes the fetched instruction.
REQ-006 BranchAddr_i  input  32  redirect target, sampled when Branch_i=1.
REQ-007 MemReq_o  output  1  instruction-memory request.
REQ-008 MemAddr_o  output  32  request address.
REQ-009 MemAck_i  input  1  memory completion; MemData_i valid in the same cycle.
REQ-010 MemData_i  input  32  instruction word.
REQ-011 PC_o  output  32  fetched instruction address + 4, to IF_ID PC_i.
REQ-012 ReadData_o  output  32  fetched instruction, to IF_ID ReadData_i; 32'b0 (NOP) when Valid_o=0.
REQ-013 Valid_o  output  1  PC_o/ReadData_o carry a real instruction this cycle.

Function
REQ-014 State machine SHALL have exactly three states: FETCH, HOLD, DROP.
REQ-015 Internal registers: PC (next fetch address), ReqAddr (outstanding request address), HoldData, HoldPC.
REQ-016 Request rule: once MemReq_o=1, MemReq_o and MemAddr_o SHALL stay stable until the edge MemAck_i=1 is sampled; no request cancellation.
REQ-017 FETCH: MemReq_o=1, MemAddr_o=ReqAddr (=PC on entry); zero-wait memory (ack in first request cycle) SHALL be supported.
REQ-018 FETCH, MemAck_i=1, Branch_i=0: Valid_o=1, ReadData_o=MemData_i, PC_o=ReqAddr+4 (combinational from MemData_i).
REQ-019 ... and HD_i=0: PC,ReqAddr <= ReqAddr+4; stay FETCH (one instruction per cycle sustained).
REQ-020 ... and HD_i=1: HoldData<=MemData_i, HoldPC<=ReqAddr+4; go HOLD.
REQ-021 FETCH, MemAck_i=0, Branch_i=0: Valid_o=0, ReadData_o=0; HD_i ignored; stay FETCH.
REQ-022 FETCH, Branch_i=1: Valid_o=0, ReadData_o=0; PC<=BranchAddr_i; with MemAck_i=1 ReqAddr<=BranchAddr_i and stay FETCH (response discarded); with MemAck_i=0 go DROP, ReqAddr unchanged.
REQ-023 HOLD: MemReq_o=0, Valid_o=1, ReadData_o=HoldData, PC_o=HoldPC.
REQ-024 HOLD, Branch_i=1: Valid_o=0, ReadData_o=0; PC,ReqAddr<=BranchAddr_i; go FETCH.
REQ-025 HOLD, Branch_i=0, HD_i=0: PC,ReqAddr<=HoldPC; go FETCH.
REQ-026 HOLD, HD_i=1, Branch_i=0: remain HOLD, outputs unchanged.
REQ-027 DROP: MemReq_o=1, MemAddr_o=ReqAddr (stale), Valid_o=0, ReadData_o=0; HD_i ignored.
REQ-028 DROP, Branch_i=1: PC<=BranchAddr_i (latest redirect wins).
REQ-029 DROP, MemAck_i=1: data discarded; ReqAddr<=PC (or BranchAddr_i if Branch_i same cycle); go FETCH.
REQ-030 Priority: Branch_i > HD_i in every state.
REQ-031 PC arithmetic: 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0; no alignment check.
REQ-032 PC_o when Valid_o=0: don't-care; SHALL not be X.

Reset
REQ-033 rst_i=1: state=FETCH, PC=ReqAddr=RESET_PC, HoldData=0, HoldPC=0, asynchronously.
REQ-034 While rst_i=1: MemReq_o=0, Valid_o=0, ReadData_o=0, PC_o=0; MemAddr_o=RESET_PC.
REQ-035 Reset during outstanding request SHALL abandon it; memory SHALL ignore a late MemAck_i; first request after release is to RESET_PC.

Verification
REQ-036 Zero-wait memory, ack always 1, no stall: fetches 0,4,8,12 on consecutive cycles; PC_o=4,8,12,16, Valid_o=1 each cycle.
REQ-037 Ack after 3 cycles for addr 0, data 32'h2002_0005: Valid_o=0 for 2 cycles, MemAddr_o=0 stable, then Valid_o=1, ReadData_o=32'h2002_0005, PC_o=4.
REQ-038 Ack for addr 8 with HD_i=1 for 2 cycles: HOLD, MemReq_o=0, ReadData_o held, PC_o=12; after HD_i=0 next request to 12.
REQ-039 Branch_i=1, BranchAddr_i=32'h40 while addr 16 outstanding (ack 2 cycles later): DROP, MemAddr_o=16 until ack, response discarded (Valid_o=0), next request to 32'h40.
REQ-040 Branch_i and HD_i both 1 in HOLD: Valid_o=0, next request to BranchAddr_i.
REQ-041 rst_i pulsed mid-request at addr 20: MemReq_o falls immediately; after release request to RESET_PC; PC wrap from 32'hFFFF_FFFC yields PC_o=0.
